// File: rtl/irq_scheduler.sv
// Raster interrupt scheduler: counts HSYNC ends, raises INT_n every
// INT_PERIOD lines and resynchronises to the frame after VSYNC.
module irq_scheduler #(
  parameter int CNT_W      = 6,
  parameter int INT_PERIOD = 52,
  parameter int VS_DELAY   = 2,
  parameter int VS_THRESH  = 32
) (
  input  logic             CLK_n,
  input  logic             RESET_n,
  input  logic             HSYNC,
  input  logic             VSYNC,
  input  logic             M1_n,
  input  logic             IORQ_n,
  input  logic             IRQ_RESET,
  output logic             INT_n,
  output logic [CNT_W-1:0] LINE_CNT
);

  localparam int DW = (VS_DELAY > 1) ? $clog2(VS_DELAY + 1) : 1;
  localparam logic [CNT_W-1:0] PERIOD = CNT_W'(INT_PERIOD);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(VS_THRESH);
  localparam logic [DW-1:0]    DELAY  = DW'(VS_DELAY);

  typedef enum logic [1:0] {
    VS_IDLE,
    VS_ARM,
    VS_WAIT
  } vs_state_t;

  vs_state_t        state, state_nxt;
  logic [DW-1:0]    dly, dly_nxt;
  logic             hs_q, vs_q, ack_q;
  logic             hs_end, vs_rise, ack;
  logic             resync;
  logic [CNT_W-1:0] cnt_nxt;
  logic             irq_nxt;

  assign hs_end  = hs_q & ~HSYNC;
  assign vs_rise = ~vs_q & VSYNC;
  assign ack     = ~M1_n & ~IORQ_n & ~ack_q;

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly;
    resync    = 1'b0;
    unique case (state)
      VS_IDLE: begin
        if (vs_rise) begin
          state_nxt = VS_ARM;
          dly_nxt   = '0;
        end
      end
      VS_ARM: begin
        if (hs_end) begin
          dly_nxt = dly + 1'b1;
          if (dly_nxt == DELAY) begin
            resync    = 1'b1;
            state_nxt = VS_WAIT;
          end
        end
      end
      VS_WAIT: begin
        if (!VSYNC) state_nxt = VS_IDLE;
      end
      default: state_nxt = VS_IDLE;
    endcase
  end

  // A resync coinciding with IRQ_RESET is swallowed by the reset branch.
  always_comb begin
    cnt_nxt = LINE_CNT;
    irq_nxt = ~INT_n;
    if (IRQ_RESET) begin
      cnt_nxt = '0;
      irq_nxt = 1'b0;
    end else begin
      if (ack && irq_nxt) begin
        irq_nxt              = 1'b0;
        cnt_nxt[CNT_W-1]     = 1'b0;
      end
      if (hs_end) begin
        if (resync) begin
          if (cnt_nxt >= THRESH) irq_nxt = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt_nxt + 1'b1;
          if (cnt_nxt == PERIOD) begin
            cnt_nxt = '0;
            irq_nxt = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      ack_q    <= 1'b0;
      state    <= VS_IDLE;
      dly      <= '0;
      INT_n    <= 1'b1;
      LINE_CNT <= '0;
    end else begin
      hs_q     <= HSYNC;
      vs_q     <= VSYNC;
      ack_q    <= ~M1_n & ~IORQ_n;
      state    <= state_nxt;
      dly      <= dly_nxt;
      INT_n    <= ~irq_nxt;
      LINE_CNT <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_irq_scheduler.sv
// Bench for irq_scheduler: reference model feeds an expected-value
// queue, directed scenarios add fixed-value checks.
module tb_irq_scheduler;

  logic       CLK_n = 1'b0;
  logic       RESET_n = 1'b0;
  logic       HSYNC = 1'b0;
  logic       VSYNC = 1'b0;
  logic       M1_n = 1'b1;
  logic       IORQ_n = 1'b1;
  logic       IRQ_RESET = 1'b0;
  logic       INT_n;
  logic [5:0] LINE_CNT;

  int total = 0;
  int bad = 0;

  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];
  logic [6:0] e, o;

  int m_cnt, m_st, m_dly;
  bit m_int, m_hs, m_vs, m_ack;

  irq_scheduler dut (
    .CLK_n(CLK_n),
    .RESET_n(RESET_n),
    .HSYNC(HSYNC),
    .VSYNC(VSYNC),
    .M1_n(M1_n),
    .IORQ_n(IORQ_n),
    .IRQ_RESET(IRQ_RESET),
    .INT_n(INT_n),
    .LINE_CNT(LINE_CNT)
  );

  always #5 CLK_n = ~CLK_n;

  function automatic void mreset();
    m_cnt = 0; m_st = 0; m_dly = 0;
    m_int = 0; m_hs = 0; m_vs = 0; m_ack = 0;
  endfunction

  function automatic void mstep();
    bit hse, vsr, ak, rs, i;
    int c;
    hse = m_hs && !HSYNC;
    vsr = !m_vs && VSYNC;
    ak  = !M1_n && !IORQ_n && !m_ack;
    rs  = 0;
    case (m_st)
      0: if (vsr) begin m_st = 1; m_dly = 0; end
      1: if (hse) begin
           m_dly = m_dly + 1;
           if (m_dly == 2) begin rs = 1; m_st = 2; end
         end
      default: if (!VSYNC) m_st = 0;
    endcase
    c = m_cnt;
    i = m_int;
    if (IRQ_RESET) begin
      c = 0; i = 0;
    end else begin
      if (ak && i) begin i = 0; c = c % 32; end
      if (hse) begin
        if (rs) begin
          if (c >= 32) i = 1;
          c = 0;
        end else begin
          c = (c + 1) % 64;
          if (c == 52) begin c = 0; i = 1; end
        end
      end
    end
    m_cnt = c; m_int = i;
    m_hs = HSYNC; m_vs = VSYNC; m_ack = !M1_n && !IORQ_n;
    exp_q.push_back({~i, 6'(c)});
  endfunction

  // Called just after a negedge with inputs already set.
  task automatic tick();
    mstep();
    @(posedge CLK_n);
    #1;
    obs_q.push_back({INT_n, LINE_CNT});
    @(negedge CLK_n);
  endtask

  task automatic pulse(input int n);
    for (int k = 0; k < n; k++) begin
      HSYNC = 1'b1; tick();
      HSYNC = 1'b0; tick();
    end
  endtask

  task automatic test_reset();
    @(negedge CLK_n);
    total++;
    if ({INT_n, LINE_CNT} !== 7'h40) begin
      bad++;
      $display("FAIL reset got=%h exp=%h", {INT_n, LINE_CNT}, 7'h40);
    end
    RESET_n = 1'b1;
    mreset();
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_period();
    pulse(51);
    total++;
    if ({INT_n, LINE_CNT} !== {1'b1, 6'd51}) begin
      bad++;
      $display("FAIL period51 got=%h exp=%h", {INT_n, LINE_CNT}, {1'b1, 6'd51});
    end
    pulse(1);
    total++;
    if ({INT_n, LINE_CNT} !== {1'b0, 6'd0}) begin
      bad++;
      $display("FAIL period52 got=%h exp=%h", {INT_n, LINE_CNT}, 7'h00);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL period_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_ack();
    pulse(40);
    M1_n = 1'b0; IORQ_n = 1'b0;
    tick();
    total++;
    if ({INT_n, LINE_CNT} !== {1'b1, 6'd8}) begin
      bad++;
      $display("FAIL ack_first got=%h exp=%h", {INT_n, LINE_CNT}, {1'b1, 6'd8});
    end
    tick();
    tick();
    total++;
    if ({INT_n, LINE_CNT} !== {1'b1, 6'd8}) begin
      bad++;
      $display("FAIL ack_hold got=%h exp=%h", {INT_n, LINE_CNT}, {1'b1, 6'd8});
    end
    M1_n = 1'b1; IORQ_n = 1'b1;
    tick();
    // Wide HSYNC pulse counts once, at its trailing edge.
    HSYNC = 1'b1;
    repeat (12) tick();
    HSYNC = 1'b0;
    tick();
    total++;
    if (LINE_CNT !== 6'd9) begin
      bad++;
      $display("FAIL wide_hsync got=%0d exp=9", LINE_CNT);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL ack_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_vsync_hi();
    pulse(26);
    VSYNC = 1'b1;
    tick();
    pulse(1);
    total++;
    if ({INT_n, LINE_CNT} !== {1'b1, 6'd36}) begin
      bad++;
      $display("FAIL vs_hi_first got=%h exp=%h", {INT_n, LINE_CNT}, {1'b1, 6'd36});
    end
    pulse(1);
    total++;
    if ({INT_n, LINE_CNT} !== {1'b0, 6'd0}) begin
      bad++;
      $display("FAIL vs_hi_resync got=%h exp=%h", {INT_n, LINE_CNT}, 7'h00);
    end
    VSYNC = 1'b0;
    M1_n = 1'b0; IORQ_n = 1'b0;
    tick();
    M1_n = 1'b1; IORQ_n = 1'b1;
    pulse(51);
    total++;
    if (INT_n !== 1'b1) begin
      bad++;
      $display("FAIL vs_hi_next51 got=%b exp=1", INT_n);
    end
    pulse(1);
    total++;
    if ({INT_n, LINE_CNT} !== {1'b0, 6'd0}) begin
      bad++;
      $display("FAIL vs_hi_next52 got=%h exp=%h", {INT_n, LINE_CNT}, 7'h00);
    end
    M1_n = 1'b0; IORQ_n = 1'b0;
    tick();
    M1_n = 1'b1; IORQ_n = 1'b1;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL vs_hi_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_vsync_lo();
    pulse(10);
    VSYNC = 1'b1;
    tick();
    pulse(1);
    total++;
    if (LINE_CNT !== 6'd11) begin
      bad++;
      $display("FAIL vs_lo_first got=%0d exp=11", LINE_CNT);
    end
    pulse(1);
    total++;
    if ({INT_n, LINE_CNT} !== {1'b1, 6'd0}) begin
      bad++;
      $display("FAIL vs_lo_resync got=%h exp=%h", {INT_n, LINE_CNT}, 7'h40);
    end
    VSYNC = 1'b0;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL vs_lo_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_irq_reset_hit();
    pulse(51);
    HSYNC = 1'b1;
    tick();
    HSYNC = 1'b0; IRQ_RESET = 1'b1;
    tick();
    IRQ_RESET = 1'b0;
    total++;
    if ({INT_n, LINE_CNT} !== {1'b1, 6'd0}) begin
      bad++;
      $display("FAIL irq_reset_hit got=%h exp=%h", {INT_n, LINE_CNT}, 7'h40);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL irq_reset_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_async_reset();
    pulse(72);
    total++;
    if ({INT_n, LINE_CNT} !== {1'b0, 6'd20}) begin
      bad++;
      $display("FAIL pre_reset got=%h exp=%h", {INT_n, LINE_CNT}, {1'b0, 6'd20});
    end
    #2;
    RESET_n = 1'b0;
    #1;
    total++;
    if ({INT_n, LINE_CNT} !== {1'b1, 6'd0}) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", {INT_n, LINE_CNT}, 7'h40);
    end
    @(negedge CLK_n);
    RESET_n = 1'b1;
    mreset();
    pulse(51);
    total++;
    if ({INT_n, LINE_CNT} !== {1'b1, 6'd51}) begin
      bad++;
      $display("FAIL post_reset51 got=%h exp=%h", {INT_n, LINE_CNT}, {1'b1, 6'd51});
    end
    pulse(1);
    total++;
    if (INT_n !== 1'b0) begin
      bad++;
      $display("FAIL post_reset52 got=%b exp=0", INT_n);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL async_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      HSYNC = ($urandom_range(0, 2) == 0) ? ~HSYNC : HSYNC;
      if ($urandom_range(0, 60) == 0) VSYNC = ~VSYNC;
      M1_n = ($urandom_range(0, 9) != 0);
      IORQ_n = ($urandom_range(0, 4) != 0);
      IRQ_RESET = ($urandom_range(0, 199) == 0);
      tick();
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL random_%0d got=%h exp=%h", k, o, e);
      end
    end
    M1_n = 1'b1; IORQ_n = 1'b1; IRQ_RESET = 1'b0;
  endtask

  initial begin
    mreset();
    test_reset();
    test_period();
    test_ack();
    test_vsync_hi();
    test_vsync_lo();
    test_irq_reset_hit();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
